// File: rtl/shadow_pkg.sv
// rtl/shadow_pkg.sv - shared defaults and pointer helper for the shadow frame buffer
package shadow_pkg;

    localparam int DATA_SIZE_BITS_DEF = 16;
    localparam int IMG_SIDELENGTH_DEF = 64;
    localparam int NUM_BANKS_DEF      = 2;

    // Bank pointers wrap at n-1 rather than at a power of two.
    function automatic int ptr_inc(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/shadow_bank.sv
// rtl/shadow_bank.sv - one frame of storage, written one row per cycle
module shadow_bank
    import shadow_pkg::*;
#(
    parameter int DATA_SIZE_BITS = DATA_SIZE_BITS_DEF,
    parameter int IMG_SIDELENGTH = IMG_SIDELENGTH_DEF
) (
    input  logic                                                         clk,
    input  logic                                                         rst_n,
    input  logic                                                         wr_en,
    input  logic [$clog2(IMG_SIDELENGTH)-1:0]                            wr_row_idx,
    input  logic [IMG_SIDELENGTH-1:0][DATA_SIZE_BITS-1:0]                wr_row,
    output logic [IMG_SIDELENGTH-1:0][IMG_SIDELENGTH-1:0][DATA_SIZE_BITS-1:0] frame
);

    logic [IMG_SIDELENGTH-1:0][IMG_SIDELENGTH-1:0][DATA_SIZE_BITS-1:0] frame_q;
    logic [IMG_SIDELENGTH-1:0][IMG_SIDELENGTH-1:0][DATA_SIZE_BITS-1:0] frame_d;

    // A row carries one pixel per column x, landing at [x][wr_row_idx].
    always_comb begin
        frame_d = frame_q;
        if (wr_en) begin
            for (int x = 0; x < IMG_SIDELENGTH; x++) begin
                frame_d[x][wr_row_idx] = wr_row[x];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign frame = frame_q;

endmodule

// File: rtl/shadow_frame_buffer.sv
// rtl/shadow_frame_buffer.sv - N-bank row-serial in, parallel-frame out shadow buffer
module shadow_frame_buffer
    import shadow_pkg::*;
#(
    parameter int DATA_SIZE_BITS = DATA_SIZE_BITS_DEF,
    parameter int IMG_SIDELENGTH = IMG_SIDELENGTH_DEF,
    parameter int NUM_BANKS      = NUM_BANKS_DEF
) (
    input  logic                                                              clk,
    input  logic                                                              rst_n,
    input  logic                                                              in_valid,
    output logic                                                              in_ready,
    input  logic [IMG_SIDELENGTH-1:0][DATA_SIZE_BITS-1:0]                     in_row,
    input  logic                                                              in_abort,
    output logic [$clog2(IMG_SIDELENGTH)-1:0]                                 in_row_idx,
    output logic                                                              out_valid,
    output logic [IMG_SIDELENGTH-1:0][IMG_SIDELENGTH-1:0][DATA_SIZE_BITS-1:0] out_frame,
    input  logic                                                              out_release,
    output logic [$clog2(NUM_BANKS)-1:0]                                      out_bank
);

    localparam int PTR_W = $clog2(NUM_BANKS);
    localparam int ROW_W = $clog2(IMG_SIDELENGTH);
    localparam int CNT_W = $clog2(NUM_BANKS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BANKS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_SIDELENGTH - 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] full_cnt_q, full_cnt_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;

    logic accept, complete, release_fire;
    logic [NUM_BANKS-1:0] bank_wr_en;
    logic [IMG_SIDELENGTH-1:0][IMG_SIDELENGTH-1:0][DATA_SIZE_BITS-1:0] bank_frame [NUM_BANKS];

    assign in_ready   = (full_cnt_q < FULL_CNT);
    assign out_valid  = (full_cnt_q != '0);
    assign out_bank   = rd_ptr_q;
    assign in_row_idx = row_cnt_q;

    // in_ready guarantees wr_ptr never points at a complete, unreleased bank.
    always_comb begin
        accept       = in_valid && in_ready && !in_abort;
        complete     = accept && (row_cnt_q == ROW_LAST);
        release_fire = out_release && out_valid;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        full_cnt_d = full_cnt_q;
        row_cnt_d  = row_cnt_q;

        if (in_abort) begin
            row_cnt_d = '0;
        end else if (accept) begin
            row_cnt_d = complete ? '0 : row_cnt_q + ROW_W'(1);
        end

        if (complete) begin
            wr_ptr_d = PTR_W'(ptr_inc(int'(wr_ptr_q), NUM_BANKS));
        end
        if (release_fire) begin
            rd_ptr_d = PTR_W'(ptr_inc(int'(rd_ptr_q), NUM_BANKS));
        end

        if (complete && !release_fire) begin
            full_cnt_d = full_cnt_q + CNT_W'(1);
        end else if (release_fire && !complete) begin
            full_cnt_d = full_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_cnt_q <= '0;
            row_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_cnt_q <= full_cnt_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_wr_en[b] = accept && (wr_ptr_q == PTR_W'(b));

        shadow_bank #(
            .DATA_SIZE_BITS (DATA_SIZE_BITS),
            .IMG_SIDELENGTH (IMG_SIDELENGTH)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (bank_wr_en[b]),
            .wr_row_idx (row_cnt_q),
            .wr_row     (in_row),
            .frame      (bank_frame[b])
        );
    end

    // Zero gating keeps stale or partial bank contents invisible when nothing is presented.
    assign out_frame = out_valid ? bank_frame[rd_ptr_q] : '0;

endmodule

// File: tb/tb_shadow_frame_buffer.sv
// tb/tb_shadow_frame_buffer.sv - directed self-checking bench for shadow_frame_buffer
module tb_shadow_frame_buffer;

    localparam int DW = 8;
    localparam int SL = 4;
    localparam int NB = 2;

    typedef logic [SL-1:0][DW-1:0]         row_t;
    typedef logic [SL-1:0][SL-1:0][DW-1:0] frame_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    row_t       in_row;
    logic       in_abort;
    logic [1:0] in_row_idx;
    logic       out_valid;
    frame_t     out_frame;
    logic       out_release;
    logic [0:0] out_bank;

    int compared   = 0;
    int mismatched = 0;

    shadow_frame_buffer #(
        .DATA_SIZE_BITS (DW),
        .IMG_SIDELENGTH (SL),
        .NUM_BANKS      (NB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .in_abort    (in_abort),
        .in_row_idx  (in_row_idx),
        .out_valid   (out_valid),
        .out_frame   (out_frame),
        .out_release (out_release),
        .out_bank    (out_bank)
    );

    always #5 clk = ~clk;

    function automatic row_t row_of(input logic [7:0] seed, input logic [7:0] mul, input int y);
        row_t r;
        for (int x = 0; x < SL; x++) begin
            r[x] = 8'(int'(seed) + int'(mul) * (16 * y + x));
        end
        return r;
    endfunction

    function automatic frame_t frame_of(input logic [7:0] seed, input logic [7:0] mul);
        frame_t f;
        row_t   r;
        for (int y = 0; y < SL; y++) begin
            r = row_of(seed, mul, y);
            for (int x = 0; x < SL; x++) begin
                f[x][y] = r[x];
            end
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input logic [7:0] seed, input logic [7:0] mul, input logic rel_last);
        for (int y = 0; y < SL; y++) begin
            in_valid = 1'b1;
            in_row   = row_of(seed, mul, y);
            if (y == SL - 1) out_release = rel_last;
            step();
        end
        in_valid    = 1'b0;
        out_release = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_row = '0; in_abort = 1'b0; out_release = 1'b0;
        step();
        step();
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_frame", out_frame, 0);
        chk("reset_out_bank", out_bank, 0);
        chk("reset_row_idx", in_row_idx, 0);
        rst_n = 1'b1;
        step();

        // single frame, pixel = 16*y + x
        for (int y = 0; y < SL; y++) begin
            chk("single_row_idx", in_row_idx, y);
            if (y == SL - 1) chk("single_not_valid_early", out_valid, 0);
            in_valid = 1'b1;
            in_row   = row_of(8'h00, 8'h01, y);
            step();
        end
        in_valid = 1'b0;
        chk("single_row_idx_wrap", in_row_idx, 0);
        chk("single_out_valid", out_valid, 1);
        chk("single_pix_2_3", out_frame[2][3], 8'h32);
        chk("single_out_bank", out_bank, 0);
        chk("single_frame", out_frame, frame_of(8'h00, 8'h01));

        // back-pressure
        write_frame(8'h40, 8'h01, 1'b0);
        chk("bp_in_ready_low", in_ready, 0);
        in_valid = 1'b1;
        in_row   = row_of(8'h99, 8'h01, 0);
        step();
        step();
        chk("bp_row_idx_held", in_row_idx, 0);
        chk("bp_in_ready_still_low", in_ready, 0);
        chk("bp_front_stable", out_frame, frame_of(8'h00, 8'h01));
        in_valid    = 1'b0;
        out_release = 1'b1;
        step();
        out_release = 1'b0;
        chk("bp_in_ready_rise", in_ready, 1);
        chk("bp_out_bank", out_bank, 1);
        chk("bp_second_frame", out_frame, frame_of(8'h40, 8'h01));
        out_release = 1'b1;
        step();
        out_release = 1'b0;
        chk("bp_empty_valid", out_valid, 0);
        chk("bp_empty_frame", out_frame, 0);

        // abort after two rows, abort beat carries in_valid
        for (int y = 0; y < 2; y++) begin
            in_valid = 1'b1;
            in_row   = row_of(8'h10, 8'h01, y);
            step();
        end
        in_abort = 1'b1;
        in_row   = row_of(8'h10, 8'h01, 2);
        step();
        in_abort = 1'b0;
        chk("abort_row_idx", in_row_idx, 0);
        for (int y = 0; y < SL; y++) begin
            if (y == SL - 1) begin
                chk("abort_row_idx_3", in_row_idx, 3);
                chk("abort_not_valid_early", out_valid, 0);
            end
            in_valid = 1'b1;
            in_row   = row_of(8'hAA, 8'h00, y);
            step();
        end
        in_valid = 1'b0;
        chk("abort_out_valid", out_valid, 1);
        chk("abort_frame_aa", out_frame, frame_of(8'hAA, 8'h00));
        chk("abort_out_bank", out_bank, 0);
        chk("abort_one_full", in_ready, 1);

        // completion and release on the same edge
        write_frame(8'h80, 8'h01, 1'b1);
        chk("simul_out_valid", out_valid, 1);
        chk("simul_out_bank", out_bank, 1);
        chk("simul_in_ready", in_ready, 1);
        chk("simul_frame", out_frame, frame_of(8'h80, 8'h01));
        out_release = 1'b1;
        step();
        out_release = 1'b0;
        chk("simul_drain", out_valid, 0);

        // spurious release while empty, then wrap-around
        out_release = 1'b1;
        step();
        out_release = 1'b0;
        chk("spur_out_valid", out_valid, 0);
        chk("spur_out_bank", out_bank, 0);
        chk("spur_in_ready", in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            write_frame(8'(k * 17 + 3), 8'h01, 1'b0);
            chk("wrap_out_bank", out_bank, k % 2);
            chk("wrap_frame", out_frame, frame_of(8'(k * 17 + 3), 8'h01));
            out_release = 1'b1;
            step();
            out_release = 1'b0;
        end
        chk("wrap_drained", out_valid, 0);

        // reset in the middle of a second frame
        write_frame(8'h21, 8'h01, 1'b0);
        chk("rst_pre_bank", out_bank, 1);
        for (int y = 0; y < 2; y++) begin
            in_valid = 1'b1;
            in_row   = row_of(8'h50, 8'h01, y);
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_frame", out_frame, 0);
        chk("rst_row_idx", in_row_idx, 0);
        step();
        rst_n = 1'b1;
        write_frame(8'h66, 8'h01, 1'b0);
        chk("rst_after_bank", out_bank, 0);
        chk("rst_after_frame", out_frame, frame_of(8'h66, 8'h01));
        chk("rst_after_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shadow_frame_buffer.md
# shadow_frame_buffer

- Multi-bank shadow store for full image frames.
- A producer writes one image row per cycle into a back bank over a valid/ready handshake.
- A consumer sees the oldest complete frame as a full parallel 2-D array, held stable until the consumer releases it.
- Sits between row-serial image producers and the parallel-array compute stages. It replaces single-bank, load-enable shadowing with N-deep buffering, back-pressure and frame abort.

## Interface
Parameters:
- DATA_SIZE_BITS, 16, width of one pixel
- IMG_SIDELENGTH, 64, frame is IMG_SIDELENGTH x IMG_SIDELENGTH pixels; one row = IMG_SIDELENGTH pixels
- NUM_BANKS, 2, number of frame banks, legal range 2..8

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer presents a row
- in_ready  out  1  buffer can accept a row
- in_row  in  [DATA_SIZE_BITS-1:0] x [IMG_SIDELENGTH-1:0]  one row, element [x] = pixel column x
- in_abort  in  1  discard the partially written frame
- in_row_idx  out  $clog2(IMG_SIDELENGTH)  index of the next row to be written
- out_valid  out  1  a complete frame is presented
- out_frame  out  [DATA_SIZE_BITS-1:0] x [IMG_SIDELENGTH-1:0] x [IMG_SIDELENGTH-1:0]  front frame, indexed [x][y]
- out_release  in  1  consumer is done with the front frame
- out_bank  out  $clog2(NUM_BANKS)  bank index currently at front

## Operation
- **State:**
  - wr_ptr, rd_ptr: bank indices, wrap NUM_BANKS-1 -> 0.
  - full_cnt: 0..NUM_BANKS.
  - row_cnt: 0..IMG_SIDELENGTH-1.
  - Bank storage: NUM_BANKS frames.
- **Derived outputs:**
  - in_ready = (full_cnt < NUM_BANKS).
  - out_valid = (full_cnt != 0).
  - out_bank = rd_ptr.
  - in_row_idx = row_cnt.
- **Accept:** occurs when in_valid && in_ready && !in_abort.
  - Writes in_row into bank[wr_ptr] at row y = row_cnt: pixel [x][row_cnt] <= in_row[x].
  - row_cnt increments.
- **Frame complete:** an accept with row_cnt == IMG_SIDELENGTH-1.
  - row_cnt -> 0, wr_ptr advances, full_cnt increments.
- **Release:** out_release && out_valid.
  - rd_ptr advances, full_cnt decrements.
  - out_release while out_valid = 0 is ignored.
- **Frame complete and release in the same cycle:** full_cnt unchanged, both pointers advance.
- **Abort:**
  - row_cnt -> 0; wr_ptr and full_cnt are unchanged.
  - Abort wins over a simultaneous accept: that row is not written and is not counted.
  - Abort on the last row means the frame never completes.
  - Rows already written into the aborted bank are stale. Later frames overwrite them before that bank can be presented.
- **Banks:**
  - A complete bank is never written until it has been released.
  - The front bank never changes content while out_valid = 1.
- **out_frame:**
  - equals bank[rd_ptr] when out_valid = 1;
  - is all-zero when out_valid = 0.
- **Back-pressure:** with all banks full, in_ready = 0. The producer holds in_row; nothing is written.

## Timing
- **Reset** (asynchronous on rst_n low, released synchronously to clk by the system):
  - all banks zero;
  - wr_ptr = rd_ptr = full_cnt = row_cnt = 0;
  - in_ready = 1, out_valid = 0, out_frame = 0, out_bank = 0, in_row_idx = 0.
- **Reset mid-frame or with full banks:** all state is lost, with no partial output.
- **Fill latency:** a frame needs exactly IMG_SIDELENGTH accepts.
  - out_valid rises in the cycle after the edge that accepts the last row, provided full_cnt was 0.
  - Minimum latency from first row to out_valid is IMG_SIDELENGTH cycles.
- **Release:** the next frame, or out_valid = 0, is visible in the cycle after the release edge.
- **in_ready:**
  - falls in the cycle after the completing accept that makes full_cnt = NUM_BANKS;
  - rises in the cycle after a release.
- **Combinational paths:**
  - in_ready, out_valid and out_frame depend only on registered state.
  - There is no combinational path from any input to any output.
- **Throughput:** one row per cycle, sustained, while the consumer releases at least one frame per IMG_SIDELENGTH cycles.

## Structure
- **Package shadow_pkg:**
  - default constants DATA_SIZE_BITS_DEF = 16, IMG_SIDELENGTH_DEF = 64, NUM_BANKS_DEF = 2;
  - function ptr_inc(ptr, n), which performs the wrap increment.
- **Sub-module shadow_bank:** one frame of storage, instantiated NUM_BANKS times.
  - Ports: clk, rst_n, wr_en, wr_row_idx, wr_row, frame.
  - Asynchronous clear; writes one row per cycle when wr_en is high.
- **Top level:** pointer/counter control, the bank select mux for out_frame, and zero gating.

## Test plan
Bench uses DATA_SIZE_BITS = 8, IMG_SIDELENGTH = 4, NUM_BANKS = 2.
- **Single frame:** 4 consecutive accepts of rows with pixel value = 16*y + x.
  - out_valid = 1 in the cycle after the 4th accept.
  - out_frame[2][3] = 0x32, out_bank = 0.
  - in_row_idx sequence 0, 1, 2, 3, 0.
- **Back-pressure:** write 2 frames with no release.
  - in_ready = 0 afterward; a held in_valid does not change row_cnt.
  - Release -> in_ready = 1 next cycle, out_bank = 1, out_frame = second frame.
- **Abort:** 2 rows, then in_abort together with in_valid, then 4 rows of 0xAA.
  - Presented frame is all 0xAA; full_cnt = 1; the aborted beat is not counted.
- **Simultaneous events:** banks hold 1 frame; the last-row accept of frame 2 coincides with a release.
  - out_valid stays 1, out_bank advances to 1, in_ready stays 1.
- **Spurious release and wrap-around:**
  - out_release while empty has no effect.
  - Run 5 frames with one release each -> out_bank sequence 0, 1, 0, 1, 0, and each frame's data matches.
- **Reset mid-frame:** rst_n low for 1 cycle after 2 rows of a second frame.
  - Immediately: out_valid = 0, out_frame = 0, in_row_idx = 0.
  - Next full frame is presented from bank 0.
